// File: rtl/stretch_sequencer.sv
// -----------------------------------------------------------------------------
// stretch_sequencer
//
// Per-channel programmable, retriggerable pulse stretcher for the trigger front
// end. Each channel holds a stretch length; a rising edge on a channel input
// produces an output pulse of that many clock cycles. If another rising edge
// arrives while the pulse is still running, the pulse restarts at full length.
// A global arm/drain/disarm sequencer gates all channels. Stretch lengths can be
// written only while the block is DISARMED, so a length never changes under a
// running pulse.
//
// Ports
//   clk       system clock; all logic is on the rising edge
//   rst_n     asynchronous, active-low reset
//   in        raw channel inputs, already synchronous to clk
//   arm       level request: DISARMED -> ARMED (ignored while disarm=1)
//   disarm    level request: ARMED -> DRAIN (wins over arm)
//   cfg_wr    single-cycle write strobe
//   cfg_addr  channel index for the write
//   cfg_data  new stretch length (0 behaves as 1)
//   cfg_ack   1-cycle pulse: the write was accepted
//   cfg_err   1-cycle pulse: the write was rejected
//   out       stretched channel outputs, registered
//   busy      OR of all out bits, registered, aligned with out
//   state     00 DISARMED, 01 ARMED, 10 DRAIN (sequencer state, for debug)
//
// Config handshake: there is no ready signal. Every cycle with cfg_wr=1 is one
// write attempt, and back-to-back attempts are allowed. Each attempt gets
// exactly one response on the following cycle: either cfg_ack or cfg_err.
// The write takes effect on the same edge as the response.
// -----------------------------------------------------------------------------
module stretch_sequencer #(
  parameter int WIDTH       = 48,
  parameter int CNT_BITS    = 4,
  parameter int DEFAULT_LEN = 4,
  localparam int AW         = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    in,
  input  logic                arm,
  input  logic                disarm,
  input  logic                cfg_wr,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [CNT_BITS-1:0] cfg_data,
  output logic                cfg_ack,
  output logic                cfg_err,
  output logic [WIDTH-1:0]    out,
  output logic                busy,
  output logic [1:0]          state
);

  typedef enum logic [1:0] {
    DISARMED = 2'b00,
    ARMED    = 2'b01,
    DRAIN    = 2'b10
  } state_t;

  state_t              st;
  logic [WIDTH-1:0]    in_d;
  logic [WIDTH-1:0]    rise;
  logic [CNT_BITS-1:0] cnt     [WIDTH];
  logic [CNT_BITS-1:0] len     [WIDTH];
  logic [CNT_BITS-1:0] cnt_nxt [WIDTH];
  logic [WIDTH-1:0]    out_nxt;
  logic                cfg_ok;

  assign state = st;
  assign rise  = in & ~in_d;

  // A write is legal only while quiescent and only to an existing channel.
  assign cfg_ok = (st == DISARMED) && (int'(cfg_addr) < WIDTH);

  // A programmed length of 0 still gives a one-cycle pulse.
  function automatic logic [CNT_BITS-1:0] eff_len(input logic [CNT_BITS-1:0] l);
    return (l == '0) ? CNT_BITS'(1) : l;
  endfunction

  // Next counter values. out is registered from the same next value, so
  // out always equals (cnt != 0) and busy is aligned with out.
  always_comb begin
    out_nxt = '0;
    for (int ch = 0; ch < WIDTH; ch++) begin
      cnt_nxt[ch] = cnt[ch];
      case (st)
        ARMED: begin
          if (rise[ch])             cnt_nxt[ch] = eff_len(len[ch]);
          else if (cnt[ch] != '0)   cnt_nxt[ch] = cnt[ch] - CNT_BITS'(1);
        end
        DRAIN: begin
          // New edges are ignored; running pulses run to completion.
          if (cnt[ch] != '0)        cnt_nxt[ch] = cnt[ch] - CNT_BITS'(1);
        end
        default:                    cnt_nxt[ch] = '0;
      endcase
      out_nxt[ch] = (cnt_nxt[ch] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= DISARMED;
      in_d    <= '0;
      out     <= '0;
      busy    <= 1'b0;
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
      for (int ch = 0; ch < WIDTH; ch++) begin
        cnt[ch] <= '0;
        len[ch] <= CNT_BITS'(DEFAULT_LEN);
      end
    end else begin
      in_d <= in;
      out  <= out_nxt;
      busy <= |out_nxt;
      for (int ch = 0; ch < WIDTH; ch++) cnt[ch] <= cnt_nxt[ch];

      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
      if (cfg_wr) begin
        if (cfg_ok) begin
          len[cfg_addr] <= cfg_data;
          cfg_ack       <= 1'b1;
        end else begin
          cfg_err <= 1'b1;
        end
      end

      case (st)
        DISARMED: if (arm && !disarm) st <= ARMED;
        ARMED:    if (disarm)         st <= DRAIN;
        // out mirrors the current counters: leave once every pulse has ended.
        DRAIN:    if (!(|out))        st <= DISARMED;
        default:                      st <= DISARMED;
      endcase
    end
  end

endmodule
